// File: rtl/pkt_ser_pkg.sv
// Shared types and helpers for the packet serializer.
package pkt_ser_pkg;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DAT, S_PAR, S_FTR, S_GAP} state_t;

  localparam logic [3:0] HEADER_DEF = 4'b1101;
  localparam logic [3:0] FOOTER_DEF = 4'b0101;

  // Phase counter must hold the longest phase length minus one.
  function automatic int cnt_w(input int dw, input int hw, input int fw, input int gp1);
    int m;
    m = dw;
    if (hw > m) m = hw;
    if (fw > m) m = fw;
    if (gp1 > m) m = gp1;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pkt_ser_shreg.sv
// Parallel-load, MSB-first shift register with async active-low clear.
module pkt_ser_shreg #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_sh,
  output logic         o_msb
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   r_q <= '0;
    else if (i_ld) r_q <= i_ld_val;
    else if (i_sh) r_q <= r_q << 1;
  end

  assign o_msb = r_q[W-1];

endmodule

// File: rtl/pkt_ser.sv
// Packet serializer: header, len+1 data bits MSB first, optional even parity, footer, gap.
module pkt_ser import pkt_ser_pkg::*; #(
  parameter int             DW        = 32,
  parameter int             LW        = $clog2(DW),
  parameter int             HW        = 4,
  parameter logic [HW-1:0]  HEADER    = HEADER_DEF,
  parameter int             FW        = 4,
  parameter logic [FW-1:0]  FOOTER    = FOOTER_DEF,
  parameter bit             PARITY_EN = 1'b1,
  parameter int             GAP       = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] dat_i,
  input  logic [LW-1:0] len_i,
  input  logic          vld_i,
  output logic          rdy_o,
  output logic          dat_o,
  output logic          frm_o,
  output logic          busy_o
);

  localparam int            CW   = cnt_w(DW, HW, FW, GAP + 1);
  localparam logic [LW-1:0] LMAX = LW'(DW - 1);

  state_t          r_st, w_st_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [LW-1:0]   r_len, w_len, w_sh;
  logic [DW-1:0]   w_dat_ld;
  logic            r_par, r_alive;
  logic            w_acc, w_last;
  logic            w_hdr_bit, w_dat_bit, w_ftr_bit;

  // Widened compare keeps the saturation check meaningful when DW is a power of two.
  assign w_len    = ({1'b0, len_i} >= (LW+1)'(DW)) ? LMAX : len_i;
  // Align bit len to the MSB so the shifter always emits from the top.
  assign w_sh     = LMAX - w_len;
  assign w_dat_ld = dat_i << w_sh;

  assign w_last = (r_cnt == '0);
  assign rdy_o  = r_alive & ((r_st == S_IDLE)
                          | (w_last & (r_st == S_FTR) & (GAP == 0))
                          | (w_last & (r_st == S_GAP)));
  assign w_acc  = vld_i & rdy_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_st    <= S_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_par   <= 1'b0;
      r_alive <= 1'b0;
    end else begin
      r_st    <= w_st_nx;
      r_cnt   <= w_cnt_nx;
      r_alive <= 1'b1;
      if (w_acc) r_len <= w_len;
      if (w_acc)                r_par <= 1'b0;
      else if (r_st == S_DAT)   r_par <= r_par ^ w_dat_bit;
    end
  end

  always_comb begin
    w_st_nx  = r_st;
    w_cnt_nx = w_last ? r_cnt : r_cnt - CW'(1);
    case (r_st)
      S_HDR: if (w_last) begin
        w_st_nx  = S_DAT;
        w_cnt_nx = CW'(r_len);
      end
      S_DAT: if (w_last) begin
        w_st_nx  = PARITY_EN ? S_PAR : S_FTR;
        w_cnt_nx = PARITY_EN ? '0 : CW'(FW - 1);
      end
      S_PAR: begin
        w_st_nx  = S_FTR;
        w_cnt_nx = CW'(FW - 1);
      end
      S_FTR: if (w_last) begin
        w_st_nx  = (GAP == 0) ? S_IDLE : S_GAP;
        w_cnt_nx = CW'((GAP > 0) ? GAP - 1 : 0);
      end
      S_GAP: if (w_last) w_st_nx = S_IDLE;
      default: w_st_nx = S_IDLE;
    endcase
    // An accept is only possible in a ready cycle and always starts a new header.
    if (w_acc) begin
      w_st_nx  = S_HDR;
      w_cnt_nx = CW'(HW - 1);
    end
  end

  always_comb begin
    dat_o = 1'b0;
    frm_o = 1'b1;
    case (r_st)
      S_HDR:   dat_o = w_hdr_bit;
      S_DAT:   dat_o = w_dat_bit;
      S_PAR:   dat_o = r_par;
      S_FTR:   dat_o = w_ftr_bit;
      default: frm_o = 1'b0;
    endcase
  end

  assign busy_o = (r_st != S_IDLE);

  pkt_ser_shreg #(.W(HW)) u_hdr (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_ld(w_acc), .i_ld_val(HEADER),
    .i_sh(r_st == S_HDR), .o_msb(w_hdr_bit)
  );

  pkt_ser_shreg #(.W(DW)) u_dat (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_ld(w_acc), .i_ld_val(w_dat_ld),
    .i_sh(r_st == S_DAT), .o_msb(w_dat_bit)
  );

  pkt_ser_shreg #(.W(FW)) u_ftr (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_ld(w_acc), .i_ld_val(FOOTER),
    .i_sh(r_st == S_FTR), .o_msb(w_ftr_bit)
  );

endmodule
